// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Registered ALU execute stage. It computes AND/OR/ADD/XOR/SUB
//               on the operands at accept time. It buffers up to two results
//               (main + skid) behind valid/ready handshakes, and the
//               upstream ready is a registered signal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      alu_ctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [TAGW-1:0] rd_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o,
    output logic [TAGW-1:0] rd_o
);

    // ALU control encodings
    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_or  = 4'b0001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_xor = 4'b0100;
    localparam logic [3:0] c_op_sub = 4'b0110;

    // Buffer occupancy states
    localparam logic [1:0] c_st_empty = 2'd0;  // main invalid
    localparam logic [1:0] c_st_one   = 2'd1;  // main valid, skid empty
    localparam logic [1:0] c_st_full  = 2'd2;  // main and skid valid

    logic [1:0]      r_state;
    logic            r_in_ready;

    logic [XLEN-1:0] r_main_result;
    logic            r_main_zero;
    logic            r_main_illegal;
    logic [TAGW-1:0] r_main_rd;

    logic [XLEN-1:0] r_skid_result;
    logic            r_skid_zero;
    logic            r_skid_illegal;
    logic [TAGW-1:0] r_skid_rd;

    logic [XLEN-1:0] w_result;
    logic            w_zero;
    logic            w_illegal;
    logic            w_accept;
    logic            w_transfer;

    // Handshake qualifiers; flush priority is applied in the state update
    assign w_accept   = in_valid_i && r_in_ready;
    assign w_transfer = (r_state != c_st_empty) && out_ready_i;

    // Combinational ALU on the inputs being accepted. Any code other than
    // the five legal ones, including X/Z, falls to the default branch.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (alu_ctrl_i)
            c_op_and: w_result = op_a_i & op_b_i;
            c_op_or:  w_result = op_a_i | op_b_i;
            c_op_add: w_result = op_a_i + op_b_i;
            c_op_xor: w_result = op_a_i ^ op_b_i;
            c_op_sub: w_result = op_a_i - op_b_i;
            default:  w_illegal = 1'b1;
        endcase
        w_zero = !w_illegal && (w_result == '0);
    end

    // Two-entry buffer: occupancy state, registered ready and entry payloads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_empty;
            r_in_ready     <= 1'b1;
            r_main_result  <= '0;
            r_main_zero    <= 1'b0;
            r_main_illegal <= 1'b0;
            r_main_rd      <= '0;
            r_skid_result  <= '0;
            r_skid_zero    <= 1'b0;
            r_skid_illegal <= 1'b0;
            r_skid_rd      <= '0;
        end else if (flush_i) begin
            // Flush discards every entry and any input offered this cycle
            r_state    <= c_st_empty;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_accept) begin
                        r_main_result  <= w_result;
                        r_main_zero    <= w_zero;
                        r_main_illegal <= w_illegal;
                        r_main_rd      <= rd_i;
                        r_state        <= c_st_one;
                    end
                end
                c_st_one: begin
                    if (w_accept && w_transfer) begin
                        // Main leaves and the new entry takes its place
                        r_main_result  <= w_result;
                        r_main_zero    <= w_zero;
                        r_main_illegal <= w_illegal;
                        r_main_rd      <= rd_i;
                    end else if (w_accept) begin
                        // Main is stalled, so the new entry parks in the skid
                        r_skid_result  <= w_result;
                        r_skid_zero    <= w_zero;
                        r_skid_illegal <= w_illegal;
                        r_skid_rd      <= rd_i;
                        r_state        <= c_st_full;
                        r_in_ready     <= 1'b0;
                    end else if (w_transfer) begin
                        r_state <= c_st_empty;
                    end
                end
                c_st_full: begin
                    if (w_transfer) begin
                        r_main_result  <= r_skid_result;
                        r_main_zero    <= r_skid_zero;
                        r_main_illegal <= r_skid_illegal;
                        r_main_rd      <= r_skid_rd;
                        r_state        <= c_st_one;
                        r_in_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_st_empty;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state != c_st_empty);
    assign result_o    = r_main_result;
    assign zero_o      = r_main_zero;
    assign illegal_o   = r_main_illegal;
    assign rd_o        = r_main_rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Self-checking bench for alu_exec_stage. It runs a vector
//               table, hand-written stall/flush/reset sequences, and random
//               traffic scored against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    localparam int XLEN = 32;
    localparam int TAGW = 5;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [TAGW-1:0] rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [TAGW-1:0] rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_stage #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .alu_ctrl_i (alu_ctrl),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .rd_i       (rd),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .zero_o     (zero),
        .illegal_o  (illegal),
        .rd_o       (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] exp_result;
        logic            exp_zero;
        logic            exp_illegal;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            z;
        logic            ill;
        logic [TAGW-1:0] tag;
    } entry_t;

    entry_t model_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAGW-1:0] t);
        in_valid = v;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        rd       = t;
    endtask

    // Reference ALU: the architectural meaning of each control code
    function automatic entry_t ref_op(input logic [3:0] c, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b, input logic [TAGW-1:0] t);
        entry_t e;
        e.tag = t;
        e.ill = 1'b0;
        if (c == 4'd0)      e.res = a & b;
        else if (c == 4'd1) e.res = a | b;
        else if (c == 4'd2) e.res = XLEN'(a + b);
        else if (c == 4'd4) e.res = a ^ b;
        else if (c == 4'd6) e.res = XLEN'(a - b);
        else begin
            e.res = '0;
            e.ill = 1'b1;
        end
        e.z = !e.ill && (e.res == '0);
        return e;
    endfunction

    vec_t vecs[10];
    logic [3:0] legal[5];

    initial begin
        legal[0] = 4'd0; legal[1] = 4'd1; legal[2] = 4'd2; legal[3] = 4'd4; legal[4] = 4'd6;

        vecs[0] = '{4'b0110, 32'h10,       32'h10, 5'd1,  32'h0,        1'b1, 1'b0};
        vecs[1] = '{4'b0110, 32'h0,        32'h1,  5'd2,  32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[2] = '{4'b0010, 32'hFFFFFFFF, 32'h1,  5'd4,  32'h0,        1'b1, 1'b0};
        vecs[3] = '{4'b1111, 32'h9,        32'h9,  5'd5,  32'h0,        1'b0, 1'b1};
        vecs[4] = '{4'b0011, 32'h0,        32'h0,  5'd6,  32'h0,        1'b0, 1'b1};
        vecs[5] = '{4'b0100, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd7, 32'h0,   1'b1, 1'b0};
        vecs[6] = '{4'b0000, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd8, 32'h0,   1'b1, 1'b0};
        vecs[7] = '{4'b0001, 32'h80000000, 32'h1,  5'd31, 32'h80000001, 1'b0, 1'b0};
        vecs[8] = '{4'b0010, 32'h7FFFFFFF, 32'h1,  5'd9,  32'h80000000, 1'b0, 1'b0};
        vecs[9] = '{4'b0110, 32'h5,        32'h7,  5'd10, 32'hFFFFFFFE, 1'b0, 1'b0};

        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 4'd0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_result",    64'(result),    64'd0);
        check("rst_zero",      64'(zero),      64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        check("rst_rd",        64'(rd_out),    64'd0);

        // ---------------- basic ADD latency ----------------
        drive(1'b1, 4'b0010, 32'd5, 32'd7, 5'd3);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, '0);
        check("add_valid",  64'(out_valid), 64'd1);
        check("add_result", 64'(result),    64'd12);
        check("add_zero",   64'(zero),      64'd0);
        check("add_rd",     64'(rd_out),    64'd3);
        @(negedge clk);
        check("add_drained", 64'(out_valid), 64'd0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tag);
            @(negedge clk);
            drive(1'b0, 4'd0, '0, '0, '0);
            check("vec_valid",   64'(out_valid), 64'd1);
            check("vec_result",  64'(result),    64'(vecs[i].exp_result));
            check("vec_zero",    64'(zero),      64'(vecs[i].exp_zero));
            check("vec_illegal", 64'(illegal),   64'(vecs[i].exp_illegal));
            check("vec_rd",      64'(rd_out),    64'(vecs[i].tag));
            @(negedge clk);
        end

        // ---------------- stall / skid ordering ----------------
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 32'hF0F0, 32'hFF00, 5'd11);
        @(negedge clk);
        check("stall_ready1", 64'(in_ready), 64'd1);
        drive(1'b1, 4'b0001, 32'h1, 32'h2, 5'd12);
        @(negedge clk);
        check("stall_ready2", 64'(in_ready), 64'd0);
        drive(1'b1, 4'b0100, 32'hFF, 32'h0F, 5'd13);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_hold_valid",  64'(out_valid), 64'd1);
            check("stall_hold_result", 64'(result),    64'hF000);
            check("stall_hold_rd",     64'(rd_out),    64'd11);
            check("stall_hold_ready",  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_or_result", 64'(result),   64'h3);
        check("drain_or_rd",     64'(rd_out),   64'd12);
        check("drain_ready",     64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, '0);
        check("drain_xor_result", 64'(result), 64'hF0);
        check("drain_xor_rd",     64'(rd_out), 64'd13);
        @(negedge clk);
        check("drain_empty", 64'(out_valid), 64'd0);

        // ---------------- flush while FULL ----------------
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd1, 32'd2, 5'd1);
        @(negedge clk);
        drive(1'b1, 4'b0010, 32'd3, 32'd4, 5'd2);
        @(negedge clk);
        check("flush_pre_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 4'b0010, 32'd100, 32'd0, 5'd9);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 4'd0, '0, '0, '0);
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_no_ghost", 64'(out_valid), 64'd0);

        // ---------------- flush in EMPTY with ready input ----------------
        flush = 1'b1;
        drive(1'b1, 4'b0010, 32'd55, 32'd0, 5'd20);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 4'd0, '0, '0, '0);
        check("flush_discard_input", 64'(out_valid), 64'd0);

        // ---------------- async reset while FULL and stalled ----------------
        out_ready = 1'b0;
        drive(1'b1, 4'b0001, 32'd1, 32'd0, 5'd1);
        @(negedge clk);
        drive(1'b1, 4'b0001, 32'd2, 32'd0, 5'd2);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, '0);
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 32'd1, 32'd1, 5'd4);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, '0);
        check("post_rst_valid",  64'(out_valid), 64'd1);
        check("post_rst_result", 64'(result),    64'd2);
        @(negedge clk);

        // ---------------- randomized traffic vs. queue model ----------------
        model_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            entry_t e;
            logic          v, fl, rdy, acc;
            logic [3:0]    c;
            logic [XLEN-1:0] a, b;
            logic [TAGW-1:0] t;

            // Outputs now reflect the state after the previous edge
            check("rnd_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            check("rnd_in_ready",  64'(in_ready),  64'(model_q.size() < 2));
            if (model_q.size() > 0) begin
                check("rnd_result",  64'(result),  64'(model_q[0].res));
                check("rnd_zero",    64'(zero),    64'(model_q[0].z));
                check("rnd_illegal", 64'(illegal), 64'(model_q[0].ill));
                check("rnd_rd",      64'(rd_out),  64'(model_q[0].tag));
            end

            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(0, 15));
            else                           c = legal[$urandom_range(0, 4)];
            a = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : XLEN'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = XLEN'($urandom_range(0, 3));
                default: b = XLEN'($urandom);
            endcase
            t = TAGW'($urandom);

            drive(v, c, a, b, t);
            flush     = fl;
            out_ready = rdy;

            // Advance the model to the state after the coming edge
            acc = v && (model_q.size() < 2);
            if (fl) begin
                model_q.delete();
            end else begin
                if (model_q.size() > 0 && rdy) void'(model_q.pop_front());
                if (acc) begin
                    e = ref_op(c, a, b, t);
                    model_q.push_back(e);
                end
            end
            @(negedge clk);
        end

        flush = 1'b0;
        drive(1'b0, 4'd0, '0, '0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
